// File: rtl/jellyvl_fifo_async_rd_ctrl.sv
// jellyvl_fifo_async_rd_ctrl: read side of a dual-clock FIFO, drives a registered-read RAM
// and presents its words as a first-word-fall-through valid/ready stream.
module jellyvl_fifo_async_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr_bin,
   output logic [ADDR_WIDTH:0]   rd_ptr_bin,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH:0]   ram_count,
   output logic                  overflow_err
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   logic [PW-1:0]         r_wr_ptr_q;
   logic [PW-1:0]         r_rd_ptr;
   logic                  r_s1_valid;
   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_ovf;
   logic [PW-1:0]         w_count;
   logic                  w_avail;
   logic                  w_accept;
   logic                  w_rd_en;
   always_comb begin
      w_count  = r_wr_ptr_q - r_rd_ptr;
      w_avail  = r_wr_ptr_q != r_rd_ptr;
      w_accept = !r_m_valid || m_ready;
      // a new read may only overwrite the RAM output once the in-flight word can move on
      w_rd_en  = w_avail && (!r_s1_valid || w_accept);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr_q <= '0;
         r_rd_ptr   <= '0;
         r_s1_valid <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_wr_ptr_q <= wr_ptr_bin;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_s1_valid <= w_rd_en || (r_s1_valid && !w_accept);
         if (w_accept) begin
            r_m_valid <= r_s1_valid;
            if (r_s1_valid) r_m_data <= ram_rd_data;
         end
         if (w_count > DEPTH) r_ovf <= 1'b1;
      end
   end
   assign rd_ptr_bin   = r_rd_ptr;
   assign ram_rd_en    = w_rd_en;
   assign ram_rd_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
   assign m_data       = r_m_data;
   assign m_valid      = r_m_valid;
   assign ram_count    = w_count;
   assign overflow_err = r_ovf;
endmodule

// File: tb/tb_jellyvl_fifo_async_rd_ctrl.sv
// tb_jellyvl_fifo_async_rd_ctrl: directed and randomized checks of the FIFO read controller
// against a word-level model (issue order, issue time, pointer arithmetic).
module tb_jellyvl_fifo_async_rd_ctrl;
   localparam int AW = 2;
   localparam int DW = 32;
   localparam int PW = AW + 1;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] wr_ptr_bin = '0;
   logic [PW-1:0] rd_ptr_bin;
   logic [PW-1:0] ram_count;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          overflow_err;
   logic [DW-1:0] mem [4];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   jellyvl_fifo_async_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_ptr_bin(wr_ptr_bin), .rd_ptr_bin(rd_ptr_bin),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .ram_count(ram_count), .overflow_err(overflow_err)
   );
   always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: every issued word is queued with its data and the edge it was issued on;
   // it must be on the stream from the second edge after issue until it is popped.
   int            ne = 0;
   int            q_st [$];
   logic [DW-1:0] q_d [$];
   logic [PW-1:0] rd_m = '0, wq_m = '0, cnt_m, p_wr = '0, p_cnt = '0;
   logic [DW-1:0] p_dat = '0;
   bit            ovf_m = 0, p_en = 0, p_pop = 0, p_rst = 0, ev;
   always @(negedge clk) begin
      ne++;
      if (!rst_n) begin
         q_st.delete();
         q_d.delete();
         rd_m = '0;
         wq_m = '0;
         ovf_m = 0;
         chk("rst_m_data", m_data, '0);
      end else if (p_rst) begin
         if (p_pop && q_d.size() > 0) begin
            void'(q_st.pop_front());
            void'(q_d.pop_front());
         end
         if (p_en) begin
            q_st.push_back(ne);
            q_d.push_back(p_dat);
            rd_m++;
         end
         if (p_cnt > 3'd4) ovf_m = 1;
         wq_m = p_wr;
      end
      cnt_m = wq_m - rd_m;
      ev = q_st.size() > 0 && q_st[0] < ne;
      chk("rd_ptr", rd_ptr_bin, rd_m);
      chk("rd_addr", ram_rd_addr, rd_m[AW-1:0]);
      chk("ram_count", ram_count, cnt_m);
      chk("overflow", overflow_err, ovf_m);
      chk("rd_en", ram_rd_en, (wq_m != rd_m) && (q_d.size() < 2 || m_ready));
      chk("m_valid", m_valid, ev);
      if (ev) chk("m_data", m_data, q_d[0]);
      p_en  = ram_rd_en;
      p_pop = m_valid && m_ready;
      p_dat = mem[ram_rd_addr];
      p_wr  = wr_ptr_bin;
      p_cnt = cnt_m;
      p_rst = rst_n;
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      wr_ptr_bin = '0;
      m_ready = 1'b0;
      tick(2);
      chk("rst_rd_ptr", rd_ptr_bin, 0);
      chk("rst_count", ram_count, 0);
      chk("rst_rd_en", ram_rd_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_ovf", overflow_err, 0);
      rst_n = 1'b1;
   endtask
   initial begin
      logic [PW-1:0] used;
      int room, t;
      for (int i = 0; i < 4; i++) mem[i] = '0;
      // first word latency
      do_reset();
      mem[0] = 32'hD0D0_0000;
      wr_ptr_bin = 3'd1;
      tick();
      chk("t1_rd_en", ram_rd_en, 1);
      chk("t1_addr", ram_rd_addr, 0);
      tick();
      chk("t1_rd_ptr", rd_ptr_bin, 1);
      chk("t1_mv_early", m_valid, 0);
      tick();
      chk("t1_mv", m_valid, 1);
      chk("t1_data", m_data, 32'hD0D0_0000);
      m_ready = 1'b1;
      tick();
      chk("t1_popped", m_valid, 0);
      // full RAM, streaming at one word per clock
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = 32'h2000_0000 + i;
      m_ready = 1'b1;
      wr_ptr_bin = 3'd4;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("t2_count", ram_count, (k <= 5) ? 5 - k : 0);
         if (k >= 3) chk("t2_data", m_data, 32'h2000_0000 + k - 3);
         if (k >= 3) chk("t2_valid", m_valid, 1);
      end
      tick();
      chk("t2_drained", m_valid, 0);
      chk("t2_ovf", overflow_err, 0);
      // back-pressure stall then release
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = 32'h3000_0000 + i;
      wr_ptr_bin = 3'd4;
      tick(6);
      chk("t3_rd_ptr", rd_ptr_bin, 2);
      chk("t3_rd_en", ram_rd_en, 0);
      chk("t3_valid", m_valid, 1);
      chk("t3_hold", m_data, 32'h3000_0000);
      m_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t3_valid_run", m_valid, 1);
         chk("t3_data", m_data, 32'h3000_0000 + k);
      end
      tick();
      chk("t3_drained", m_valid, 0);
      // pointer wrap 6 -> 10 (mod 8)
      do_reset();
      m_ready = 1'b1;
      wr_ptr_bin = 3'd4;
      tick(8);
      mem[0] = 32'h4000_0004;
      mem[1] = 32'h4000_0005;
      wr_ptr_bin = 3'd6;
      tick(8);
      chk("t4_start", rd_ptr_bin, 6);
      m_ready = 1'b0;
      mem[2] = 32'h4000_0006;
      mem[3] = 32'h4000_0007;
      mem[0] = 32'h4000_0008;
      mem[1] = 32'h4000_0009;
      wr_ptr_bin = 3'd2;
      tick();
      chk("t4_count4", ram_count, 4);
      chk("t4_addr2", ram_rd_addr, 2);
      tick();
      chk("t4_rd_ptr7", rd_ptr_bin, 7);
      chk("t4_addr3", ram_rd_addr, 3);
      chk("t4_count3", ram_count, 3);
      tick();
      chk("t4_rd_ptr0", rd_ptr_bin, 0);
      chk("t4_stall", ram_rd_en, 0);
      chk("t4_count2", ram_count, 2);
      chk("t4_data6", m_data, 32'h4000_0006);
      m_ready = 1'b1;
      for (int k = 7; k <= 9; k++) begin
         tick();
         chk("t4_data", m_data, 32'h4000_0000 + k);
      end
      chk("t4_ovf", overflow_err, 0);
      // overflow: sticky flag, then asynchronous reset mid-stream
      do_reset();
      m_ready = 1'b1;
      wr_ptr_bin = 3'd5;
      tick();
      chk("t5_count5", ram_count, 5);
      chk("t5_ovf_late", overflow_err, 0);
      tick();
      chk("t5_ovf_set", overflow_err, 1);
      tick(8);
      chk("t5_count0", ram_count, 0);
      chk("t5_ovf_sticky", overflow_err, 1);
      wr_ptr_bin = 3'd7;
      tick(3);
      chk("t5_mid_valid", m_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_ovf", overflow_err, 0);
      chk("t5_rst_valid", m_valid, 0);
      chk("t5_rst_rd_ptr", rd_ptr_bin, 0);
      chk("t5_rst_count", ram_count, 0);
      chk("t5_rst_rd_en", ram_rd_en, 0);
      wr_ptr_bin = '0;
      tick(2);
      rst_n = 1'b1;
      // randomized producer and consumer
      tick();
      for (int c = 0; c < 3000; c++) begin
         m_ready = ($urandom_range(0, 7) < ((c / 500) % 4) * 2 + 1);
         used = wr_ptr_bin - rd_ptr_bin;
         room = 4 - int'(used);
         if (room > 2) room = 2;
         if (room > 0) begin
            for (int j = $urandom_range(0, room); j > 0; j--) begin
               mem[wr_ptr_bin[AW-1:0]] = $urandom;
               wr_ptr_bin = wr_ptr_bin + 3'd1;
            end
         end
         tick();
      end
      m_ready = 1'b1;
      t = 0;
      while (!(rd_ptr_bin == wr_ptr_bin && !m_valid) && t < 50) begin
         tick();
         t++;
      end
      chk("drain_timeout", t < 50, 1);
      chk("rand_ovf", overflow_err, 0);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jellyvl_fifo_async_rd_ctrl.md
# jellyvl_fifo_async_rd_ctrl

Read-side controller for a dual-clock FIFO built on `jellyvl_cdc_gray`. It receives the write pointer after `jellyvl_cdc_gray` has moved it into the read clock domain, and drives the read port of the shared dual-port RAM. It presents a first-word-fall-through valid/ready stream to the consumer and returns its own binary read pointer, which feeds the `src_in_bin` of the reverse-direction `jellyvl_cdc_gray`. It sits entirely in the read clock domain; the write-side controller is a separate block.

## Interface
- `ADDR_WIDTH`, default 4: RAM address bits; FIFO depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: RAM and stream data width.
- `clk`  in  1: read-domain clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr_ptr_bin`  in  ADDR_WIDTH+1: write pointer in binary, already synchronized to `clk` by `jellyvl_cdc_gray`.
- `rd_ptr_bin`  out  ADDR_WIDTH+1: registered read pointer, counting issued RAM reads; goes to the reverse `jellyvl_cdc_gray`.
- `ram_rd_en`  out  1: RAM read enable. When low, the RAM output register holds its value.
- `ram_rd_addr`  out  ADDR_WIDTH: equals `rd_ptr_bin[ADDR_WIDTH-1:0]`.
- `ram_rd_data`  in  DATA_WIDTH: RAM data, valid on the cycle after the edge where `ram_rd_en` was sampled high.
- `m_data`  out  DATA_WIDTH: stream data.
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready.
- `ram_count`  out  ADDR_WIDTH+1: `wr_ptr_q - rd_ptr_bin` (mod 2^(ADDR_WIDTH+1)), i.e. words in the RAM not yet read.
- `overflow_err`  out  1: sticky flag, set when `ram_count` > 2^ADDR_WIDTH.

## Operation
- `wr_ptr_q` is a 1-stage register of `wr_ptr_bin`. Every internal decision uses `wr_ptr_q`.
- `avail` = (`wr_ptr_q` != `rd_ptr_bin`).
- `accept` = !`m_valid` | `m_ready`. This means the output register can take new data this cycle.
- Pipeline stage `s1_valid` means a RAM read is in flight and its data is on `ram_rd_data` this cycle.
- `ram_rd_en` = `avail` & (!`s1_valid` | `accept`). This is combinational from registers and `m_ready`.
- On each edge:
  - If `ram_rd_en`: `rd_ptr_bin` += 1. It wraps from 2^(ADDR_WIDTH+1)-1 to 0.
  - `s1_valid` <= `ram_rd_en` ? 1 : (`accept` ? 0 : `s1_valid`).
  - If `accept`: `m_valid` <= `s1_valid`, and `m_data` <= `ram_rd_data` when `s1_valid`.
  - If !`accept`: `m_valid` and `m_data` hold.
- Stall rule: while `s1_valid` & !`accept`, `ram_rd_en` = 0, so the RAM output holds the in-flight word. No word is lost or duplicated.
- A RAM slot is freed at issue time. Reverse synchronization delays the write side's view by ≥2 clocks, and the data is captured by then.
- `m_valid` never drops without a handshake. `m_data` is stable while `m_valid` & !`m_ready`.
- `overflow_err` is set once `ram_count` > 2^ADDR_WIDTH and is cleared only by reset. It flags a corrupt or non-gray-safe pointer. Reads continue regardless.
- `m_valid` & `m_ready` and a new issue in the same cycle are a simultaneous pop and refill: sustained 1 word/clk.

## Timing
- Reset values: `rd_ptr_bin`, `wr_ptr_q`, `s1_valid`, `m_valid`, `m_data`, `overflow_err` all 0. `ram_rd_en` = 0 and `ram_count` = 0 during reset.
- Reset asserted mid-operation immediately clears all state. In-flight and output data are discarded. The write side must be reset together.
- Latency: `wr_ptr_bin` changes before edge k. Then:
  - `wr_ptr_q` updates at edge k.
  - `ram_rd_en` is high in cycle k..k+1.
  - `s1_valid` = 1 after edge k+1.
  - `m_valid` = 1 after edge k+2.
- Throughput: 1 word/clk with `m_ready` held high and `avail`.
- Empty (`wr_ptr_q` == `rd_ptr_bin`): `ram_rd_en` = 0, and the already-issued words drain normally.
- Full (`ram_count` = 2^ADDR_WIDTH): legal, no error.
- The address wraps naturally at depth; the pointer MSB distinguishes full from empty.

## Test plan
- Reset, ADDR_WIDTH=2: all outputs 0. Step `wr_ptr_bin` 0→1 before edge 1 → `ram_rd_en` high after edge 1 with `ram_rd_addr`=0; `m_valid`=1 after edge 3; `rd_ptr_bin`=1.
- `wr_ptr_bin`=4, `m_ready`=1 → 4 reads on consecutive clocks, addrs 0,1,2,3; `m_data` matches RAM words 0..3 on 4 consecutive handshakes; `ram_count` goes 4→0; `overflow_err` stays 0.
- `wr_ptr_bin`=4, `m_ready`=0 → exactly 2 reads issue; `ram_rd_en` then stays 0; `m_data` holds word 0. Raise `m_ready` → words 0,1,2,3 in order with no gap after the first pop.
- Wrap: pointer runs from 6 to 9 (ADDR_WIDTH=2, 3-bit pointers, 6→7→0→1 mod 8) → addresses 2,3,0,1; `ram_count` correct across the wrap.
- Jump `wr_ptr_bin` from 0 to 5 → `ram_count`=5 and `overflow_err`=1 next cycle; the flag stays set after the count drops; a mid-stream `rst_n` pulse clears it and all state.
- Random `m_ready` and pointer increments against a scoreboard → no loss, no duplication, in-order data.
